// File: rtl/inv_shift_rows.sv
// AES InvShiftRows byte permutation for the decrypt datapath.
// Row r of the 4x4 state (byte k: row k%4, col k/4, MSB-first packing) is
// rotated right by r bytes. OUT_REG=1 registers the result (1-cycle latency);
// OUT_REG=0 gives a purely combinational path.
// Optional macro ISR_FWD_MODE_EN adds a 'fwd' input selecting forward ShiftRows.
module inv_shift_rows #(
  parameter int OUT_REG = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
`ifdef ISR_FWD_MODE_EN
  input  logic         fwd,
`endif
  input  logic [127:0] isr_in,
  output logic         out_valid,
  output logic [127:0] isr_out
);

  // Row rotation: inv=1 -> out[r][c] = in[r][(c-r)%4]; inv=0 -> in[r][(c+r)%4].
  function automatic logic [127:0] shift_rows(input logic [127:0] s, input logic inv);
    logic [127:0] o;
    int src_c;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        src_c = inv ? ((c - r + 4) % 4) : ((c + r) % 4);
        o[127 - 8*(4*c + r) -: 8] = s[127 - 8*(4*src_c + r) -: 8];
      end
    end
    return o;
  endfunction

  logic         inv_p0;
  logic [127:0] perm_p0;

`ifdef ISR_FWD_MODE_EN
  assign inv_p0 = ~fwd;
`else
  assign inv_p0 = 1'b1;
`endif

  assign perm_p0 = shift_rows(isr_in, inv_p0);

  // ---- stage p0 -> p1 boundary ----
  generate
    if (OUT_REG != 0) begin : g_reg
      logic         vld_p1_d, vld_p1_q;
      logic [127:0] data_p1_d, data_p1_q;

      // Next-state: capture the permuted state only on valid input, otherwise hold
      // (keeps X on an idle isr_in from ever reaching the register).
      always_comb begin
        vld_p1_d  = in_valid;
        data_p1_d = data_p1_q;
        if (in_valid) begin
          data_p1_d = perm_p0;
        end
      end

      // Output register with asynchronous clear of both valid and data.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          vld_p1_q  <= 1'b0;
          data_p1_q <= '0;
        end else begin
          vld_p1_q  <= vld_p1_d;
          data_p1_q <= data_p1_d;
        end
      end

      assign out_valid = vld_p1_q;
      assign isr_out   = data_p1_q;
    end else begin : g_comb
      assign out_valid = in_valid;
      assign isr_out   = perm_p0;
    end
  endgenerate

endmodule

// File: tb/tb_inv_shift_rows.sv
// Directed self-checking bench for inv_shift_rows (default OUT_REG=1).
module tb_inv_shift_rows;

  logic         clk;
  logic         rst;
  logic         in_valid;
`ifdef ISR_FWD_MODE_EN
  logic         fwd;
`endif
  logic [127:0] isr_in;
  logic         out_valid;
  logic [127:0] isr_out;

  int tests_run;
  int tests_failed;

  localparam logic [127:0] VEC1 = 128'h733e7fd2760cd973104b94689bd929fc;
  localparam logic [127:0] EXP1 = 128'h73d99473763e2968100c7ffc9b4bd9d2;
  localparam logic [127:0] VEC2 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] EXP2 = 128'h000d0a0704010e0b0805020f0c090603;
  localparam logic [127:0] VEC3 = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] EXP3 = 128'h00ddaa774411eebb885522ffcc996633;
  localparam logic [127:0] FEXP2 = 128'h00050a0f04090e03080d02070c01060b;

  inv_shift_rows #(.OUT_REG(1)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
`ifdef ISR_FWD_MODE_EN
    .fwd       (fwd),
`endif
    .isr_in    (isr_in),
    .out_valid (out_valid),
    .isr_out   (isr_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_bit(input string tag, input logic obs, input logic exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: got %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic check_data(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [127:0] d);
    @(negedge clk);
    in_valid = v;
    isr_in   = d;
  endtask

  task automatic sample();
    @(posedge clk);
    #1;
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    rst      = 1'b1;
    in_valid = 1'b0;
    isr_in   = '0;
`ifdef ISR_FWD_MODE_EN
    fwd      = 1'b0;
`endif

    // Reset held
    #12;
    check_bit ("rst_vld",  out_valid, 1'b0);
    check_data("rst_data", isr_out,   128'h0);

    // Release reset, idle input
    @(negedge clk);
    rst = 1'b0;
    sample();
    check_bit ("idle_vld",  out_valid, 1'b0);
    check_data("idle_data", isr_out,   128'h0);

    // Two back-to-back valid states
    drive(1'b1, VEC1);
    sample();
    check_bit ("v1_vld",  out_valid, 1'b1);
    check_data("v1_data", isr_out,   EXP1);
    drive(1'b1, VEC2);
    sample();
    check_bit ("v2_vld",  out_valid, 1'b1);
    check_data("v2_data", isr_out,   EXP2);

    // Idle cycles: output held, junk on isr_in ignored
    drive(1'b0, 128'hxxxxxxxx_xxxxxxxx_xxxxxxxx_xxxxxxxx);
    sample();
    check_bit ("hold1_vld",  out_valid, 1'b0);
    check_data("hold1_data", isr_out,   EXP2);
    drive(1'b0, 128'hffffffff_ffffffff_ffffffff_ffffffff);
    sample();
    check_bit ("hold2_vld",  out_valid, 1'b0);
    check_data("hold2_data", isr_out,   EXP2);

    // Third pattern, then async reset between edges
    drive(1'b1, VEC3);
    sample();
    check_bit ("v3_vld",  out_valid, 1'b1);
    check_data("v3_data", isr_out,   EXP3);
    #2;
    rst = 1'b1;
    #1;
    check_bit ("arst_vld",  out_valid, 1'b0);
    check_data("arst_data", isr_out,   128'h0);
    sample();
    check_bit ("arst_hold_vld",  out_valid, 1'b0);
    check_data("arst_hold_data", isr_out,   128'h0);

    // Release reset mid-stream: first capture on first edge with rst=0
    @(negedge clk);
    rst      = 1'b0;
    in_valid = 1'b1;
    isr_in   = VEC1;
    sample();
    check_bit ("rel_vld",  out_valid, 1'b1);
    check_data("rel_data", isr_out,   EXP1);

`ifdef ISR_FWD_MODE_EN
    // Forward ShiftRows and round trip back through InvShiftRows
    @(negedge clk);
    in_valid = 1'b1;
    fwd      = 1'b1;
    isr_in   = VEC2;
    sample();
    check_bit ("fwd_vld",  out_valid, 1'b1);
    check_data("fwd_data", isr_out,   FEXP2);
    @(negedge clk);
    fwd    = 1'b0;
    isr_in = FEXP2;
    sample();
    check_data("roundtrip_data", isr_out, VEC2);
`endif

    drive(1'b0, '0);
    sample();
    check_bit ("end_vld", out_valid, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
